y86_regfile_fwd: RTL and testbench

Parametrised register file for the pipelined Y86 core, merging decode-stage operand read, priority forwarding, writeback and load-use hazard detection into one block. It sits between the D and E pipeline registers: it produces `d_valA`/`d_valB` for the E register and accepts the two W-stage writebacks. A handshaked dump port streams the architectural registers to the bench one register per beat.

---
 rtl/y86_regfile_fwd_if.sv | 23 ++
 rtl/y86_regfile_fwd.sv | 140 ++++++++++++++
 tb/tb_y86_regfile_fwd.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/y86_regfile_fwd_if.sv
// Register dump stream between the Y86 register file and whoever inspects it.
// The consumer requests a dump and applies backpressure; the register file produces the beats.
interface y86_regfile_fwd_if #(
  parameter int AW     = 4,
  parameter int DATA_W = 64
);
  logic              dump_start;
  logic              dump_ready;
  logic              dump_valid;
  logic [AW-1:0]     dump_idx;
  logic [DATA_W-1:0] dump_data;
  logic              dump_done;

  modport master (
    output dump_start, dump_ready,
    input  dump_valid, dump_idx, dump_data, dump_done
  );

  modport slave (
    input  dump_start, dump_ready,
    output dump_valid, dump_idx, dump_data, dump_done
  );
endinterface

// File: rtl/y86_regfile_fwd.sv
// Y86 decode-stage register file: operand read with lane/writeback bypass,
// dual writeback, load-use stall detection and a handshaked register dump.
module y86_regfile_fwd #(
  parameter int DATA_W = 64,
  parameter int NREG   = 15,
  parameter int AW     = 4,
  parameter int NFWD   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [AW-1:0]          i_d_srcA,
  input  logic [AW-1:0]          i_d_srcB,
  input  logic                   i_d_selP,
  input  logic [DATA_W-1:0]      i_d_valP,
  input  logic [NFWD*AW-1:0]     i_fwd_dst,
  input  logic [NFWD*DATA_W-1:0] i_fwd_val,
  input  logic [AW-1:0]          i_W_dstE,
  input  logic [AW-1:0]          i_W_dstM,
  input  logic [DATA_W-1:0]      i_W_valE,
  input  logic [DATA_W-1:0]      i_W_valM,
  input  logic [AW-1:0]          i_E_dstM,
  output logic [DATA_W-1:0]      o_d_valA,
  output logic [DATA_W-1:0]      o_d_valB,
  output logic                   o_d_stall,
  y86_regfile_fwd_if.slave       dump
);

  localparam logic [AW-1:0] RNONE = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } dump_state_t;

  logic [DATA_W-1:0] r_regs [NREG];
  dump_state_t       r_state;
  logic [AW-1:0]     r_idx;
  logic              r_valid;
  logic              r_done;

  logic [DATA_W-1:0] w_storedA;
  logic [DATA_W-1:0] w_storedB;
  logic [DATA_W-1:0] w_dumpData;

  function automatic logic srcOk(input logic [AW-1:0] src);
    return (src != RNONE) && (int'(src) < NREG);
  endfunction

  // Lowest priority is applied first so each higher-priority source overrides it.
  function automatic logic [DATA_W-1:0] resolveSrc(input logic [AW-1:0]     src,
                                                   input logic [DATA_W-1:0] stored);
    logic [DATA_W-1:0] v;
    v = stored;
    if (i_W_dstE == src) v = i_W_valE;
    if (i_W_dstM == src) v = i_W_valM;
    for (int i = NFWD - 1; i >= 0; i--) begin
      if (i_fwd_dst[i*AW +: AW] == src) v = i_fwd_val[i*DATA_W +: DATA_W];
    end
    if (!srcOk(src)) v = '0;
    return v;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (srcOk(i_W_dstE) && i_W_dstE == AW'(i)) r_regs[i] <= i_W_valE;
        if (srcOk(i_W_dstM) && i_W_dstM == AW'(i)) r_regs[i] <= i_W_valM;
      end
    end
  end

  always_comb begin
    w_storedA  = '0;
    w_storedB  = '0;
    w_dumpData = '0;
    for (int i = 0; i < NREG; i++) begin
      if (i_d_srcA == AW'(i)) w_storedA = r_regs[i];
      if (i_d_srcB == AW'(i)) w_storedB = r_regs[i];
      if (r_idx == AW'(i))    w_dumpData = r_regs[i];
    end
  end

  always_comb begin
    o_d_valA  = i_d_selP ? i_d_valP : resolveSrc(i_d_srcA, w_storedA);
    o_d_valB  = resolveSrc(i_d_srcB, w_storedB);
    o_d_stall = (i_E_dstM != RNONE) && ((i_E_dstM == i_d_srcA) || (i_E_dstM == i_d_srcB));
  end

  // Dump data is read from committed storage only, so a beat never shows bypassed values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (dump.dump_start) begin
            r_state <= ST_RUN;
            r_idx   <= '0;
            r_valid <= 1'b1;
          end
        end
        ST_RUN: begin
          if (dump.dump_ready) begin
            if (r_idx == AW'(NREG - 1)) begin
              r_state <= ST_DONE;
              r_idx   <= '0;
              r_valid <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_idx <= r_idx + AW'(1);
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= ST_IDLE;
          r_idx   <= '0;
          r_valid <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign dump.dump_valid = r_valid;
  assign dump.dump_idx   = r_idx;
  assign dump.dump_data  = w_dumpData;
  assign dump.dump_done  = r_done;

endmodule

// File: tb/tb_y86_regfile_fwd.sv
// Directed bench for y86_regfile_fwd: vector table for operand resolution and
// hazards, hand-written sequences for writeback persistence and the dump port.
module tb_y86_regfile_fwd;

  localparam logic [3:0] N = 4'hF;

  typedef struct packed {
    logic [3:0]   srcA;
    logic [3:0]   srcB;
    logic         selP;
    logic [63:0]  valP;
    logic [11:0]  fwdDst;
    logic [191:0] fwdVal;
    logic [3:0]   wDstE;
    logic [63:0]  wValE;
    logic [3:0]   wDstM;
    logic [63:0]  wValM;
    logic [3:0]   eDstM;
    logic [63:0]  expA;
    logic [63:0]  expB;
    logic         expStall;
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic [3:0]   dSrcA, dSrcB;
  logic         dSelP;
  logic [63:0]  dValP;
  logic [11:0]  fwdDst;
  logic [191:0] fwdVal;
  logic [3:0]   wDstE, wDstM, eDstM;
  logic [63:0]  wValE, wValM;
  logic [63:0]  dValA, dValB;
  logic         dStall;

  int testsRun = 0;
  int testsFailed = 0;
  vec_t vecs[$];

  y86_regfile_fwd_if #(.AW(4), .DATA_W(64)) dumpIf ();

  y86_regfile_fwd #(.DATA_W(64), .NREG(15), .AW(4), .NFWD(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_d_srcA  (dSrcA),
    .i_d_srcB  (dSrcB),
    .i_d_selP  (dSelP),
    .i_d_valP  (dValP),
    .i_fwd_dst (fwdDst),
    .i_fwd_val (fwdVal),
    .i_W_dstE  (wDstE),
    .i_W_dstM  (wDstM),
    .i_W_valE  (wValE),
    .i_W_valM  (wValM),
    .i_E_dstM  (eDstM),
    .o_d_valA  (dValA),
    .o_d_valB  (dValB),
    .o_d_stall (dStall),
    .dump      (dumpIf.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic addVec(input logic [3:0] sA, input logic [3:0] sB, input logic sel,
                        input logic [63:0] vP,
                        input logic [3:0] l0d, input logic [63:0] l0v,
                        input logic [3:0] l1d, input logic [63:0] l1v,
                        input logic [3:0] l2d, input logic [63:0] l2v,
                        input logic [3:0] wde, input logic [63:0] wve,
                        input logic [3:0] wdm, input logic [63:0] wvm,
                        input logic [3:0] ed,
                        input logic [63:0] eA, input logic [63:0] eB, input logic eS);
    vec_t v;
    v.srcA = sA; v.srcB = sB; v.selP = sel; v.valP = vP;
    v.fwdDst = {l2d, l1d, l0d};
    v.fwdVal = {l2v, l1v, l0v};
    v.wDstE = wde; v.wValE = wve; v.wDstM = wdm; v.wValM = wvm;
    v.eDstM = ed; v.expA = eA; v.expB = eB; v.expStall = eS;
    vecs.push_back(v);
  endtask

  task automatic setIdle();
    dSrcA = N; dSrcB = N; dSelP = 1'b0; dValP = '0;
    fwdDst = {N, N, N}; fwdVal = '0;
    wDstE = N; wValE = '0; wDstM = N; wValM = '0; eDstM = N;
  endtask

  task automatic applyStimulus(input vec_t v);
    dSrcA = v.srcA; dSrcB = v.srcB; dSelP = v.selP; dValP = v.valP;
    fwdDst = v.fwdDst; fwdVal = v.fwdVal;
    wDstE = v.wDstE; wValE = v.wValE; wDstM = v.wDstM; wValM = v.wValM;
    eDstM = v.eDstM;
  endtask

  task automatic runDump(input int mode, input int abortBeat);
    int  expIdx = 0;
    int  cyc = 0;
    bit  finished = 0;
    bit  sawDone = 0;
    bit  aborted = 0;
    @(negedge clk);
    dumpIf.dump_start = 1'b1;
    dumpIf.dump_ready = 1'b0;
    @(negedge clk);
    dumpIf.dump_start = 1'b0;
    #1 checkOutput("dumpFirstValid", 64'(dumpIf.dump_valid), 64'(1));
    while (!finished) begin
      if (cyc >= 200) begin
        checkOutput("dumpTimeout", 64'(cyc), 64'(0));
        break;
      end
      dumpIf.dump_ready = (mode == 0) ? 1'b1 : ((cyc % 2) == 1);
      #1;
      if (abortBeat >= 0 && dumpIf.dump_valid && int'(dumpIf.dump_idx) == abortBeat) begin
        rst_n = 1'b0;
        #1;
        checkOutput("dumpAbortValid", 64'(dumpIf.dump_valid), 64'(0));
        checkOutput("dumpAbortIdx", 64'(dumpIf.dump_idx), 64'(0));
        repeat (4) begin
          @(negedge clk);
          #1 checkOutput("dumpAbortNoDone", 64'(dumpIf.dump_done), 64'(0));
        end
        rst_n = 1'b1;
        aborted = 1;
        finished = 1;
      end else if (dumpIf.dump_done) begin
        checkOutput("dumpDoneAfterLast", 64'(expIdx), 64'(15));
        sawDone = 1;
        finished = 1;
      end else begin
        checkOutput("dumpBeatValid", 64'(dumpIf.dump_valid), 64'(1));
        checkOutput("dumpBeatIdx", 64'(dumpIf.dump_idx), 64'(expIdx));
        checkOutput("dumpBeatData", dumpIf.dump_data, 64'(expIdx + 1));
        if (dumpIf.dump_ready) expIdx++;
      end
      cyc++;
      @(negedge clk);
    end
    if (sawDone) begin
      #1;
      checkOutput("dumpDonePulse", 64'(dumpIf.dump_done), 64'(0));
      checkOutput("dumpIdleValid", 64'(dumpIf.dump_valid), 64'(0));
    end
    if (abortBeat >= 0) checkOutput("dumpAbortReached", 64'(aborted), 64'(1));
    dumpIf.dump_ready = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    dumpIf.dump_start = 1'b0;
    dumpIf.dump_ready = 1'b0;
    setIdle();
    dSrcA = 4'd3;
    #1;
    checkOutput("resetValid", 64'(dumpIf.dump_valid), 64'(0));
    checkOutput("resetIdx", 64'(dumpIf.dump_idx), 64'(0));
    checkOutput("resetDone", 64'(dumpIf.dump_done), 64'(0));
    checkOutput("resetData", dumpIf.dump_data, 64'(0));
    checkOutput("resetValA", dValA, 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    //     sA  sB sel valP   l0d l0v    l1d l1v    l2d l2v     wDstE wValE     wDstM wValM     eDstM expA       expB       stall
    addVec(3,  14, 0, 0,     N,  0,     N,  0,     N,  0,      N,    0,        N,    0,        N,    0,         0,         0);
    addVec(3,  14, 0, 0,     N,  0,     N,  0,     N,  0,      3,    'h1122,   N,    0,        N,    'h1122,    0,         0);
    addVec(3,  14, 0, 0,     N,  0,     N,  0,     N,  0,      N,    0,        N,    0,        N,    'h1122,    0,         0);
    addVec(5,  3,  0, 0,     5,  'hA,   5,  'hB,   N,  0,      N,    0,        5,    'hC,      N,    'hA,       'h1122,    0);
    addVec(5,  3,  0, 0,     N,  0,     5,  'hB,   N,  0,      N,    0,        5,    'hC,      N,    'hB,       'h1122,    0);
    addVec(5,  6,  0, 0,     N,  0,     N,  0,     6,  'h66,   6,    'h77,     5,    'hC,      N,    'hC,       'h66,      0);
    addVec(15, 6,  0, 0,     15, 'h99,  N,  0,     N,  0,      N,    0,        N,    0,        N,    0,         'h77,      0);
    addVec(5,  5,  1, 'h40,  5,  'hA,   N,  0,     N,  0,      N,    0,        N,    0,        N,    'h40,      'hA,       0);
    addVec(4,  3,  0, 0,     N,  0,     N,  0,     N,  0,      4,    'h10,     4,    'h20,     N,    'h20,      'h1122,    0);
    addVec(4,  3,  0, 0,     N,  0,     N,  0,     N,  0,      N,    0,        N,    0,        N,    'h20,      'h1122,    0);
    addVec(4,  15, 0, 0,     N,  0,     N,  0,     N,  0,      15,   'hDEAD,   15,   'hBEEF,   N,    'h20,      0,         0);
    addVec(4,  5,  0, 0,     N,  0,     N,  0,     N,  0,      N,    0,        N,    0,        N,    'h20,      'hC,       0);
    addVec(0,  2,  0, 0,     N,  0,     N,  0,     N,  0,      N,    0,        N,    0,        2,    0,         0,         1);
    addVec(2,  9,  0, 0,     N,  0,     N,  0,     N,  0,      N,    0,        N,    0,        2,    0,         0,         1);
    addVec(7,  7,  0, 0,     N,  0,     N,  0,     N,  0,      N,    0,        N,    0,        2,    0,         0,         0);
    addVec(15, 15, 0, 0,     N,  0,     N,  0,     N,  0,      N,    0,        N,    0,        15,   0,         0,         0);
    addVec(2,  0,  1, 'h8,   N,  0,     N,  0,     N,  0,      N,    0,        N,    0,        2,    'h8,       0,         1);
    addVec(0,  14, 0, 0,     N,  0,     N,  0,     N,  0,      N,    0,        14,   'h5555,   N,    0,         'h5555,    0);
    addVec(0,  14, 0, 0,     N,  0,     N,  0,     N,  0,      N,    0,        N,    0,        N,    0,         'h5555,    0);

    foreach (vecs[k]) begin
      @(negedge clk);
      applyStimulus(vecs[k]);
      #1;
      checkOutput($sformatf("vec%0d valA", k), dValA, vecs[k].expA);
      checkOutput($sformatf("vec%0d valB", k), dValB, vecs[k].expB);
      checkOutput($sformatf("vec%0d stall", k), 64'(dStall), 64'(vecs[k].expStall));
    end

    @(negedge clk);
    setIdle();
    rst_n = 1'b0;
    #1;
    dSrcA = 4'd3;
    #1 checkOutput("reresetClearsReg3", dValA, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      wDstE = 4'(i);
      wValE = 64'(i + 1);
    end
    @(negedge clk);
    setIdle();

    runDump(0, -1);
    runDump(1, -1);
    runDump(0, 6);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL globalTimeout: got stuck expected finish");
    $fatal(1, "[TB] simulation time limit expired");
  end

endmodule
